writeback_stage_vec: RTL and testbench

//  Memory->Writeback pipeline register merged with the ResultW select, generalised to
//  one scalar lane plus LANES vector lanes. Adds valid tracking, stall, flush and a
//  per-lane vector write mask. Sits between the memory stage and the register files;

---
 rtl/writeback_stage_vec.sv | 155 +++++++++++++++
 tb/tb_writeback_stage_vec.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage_vec.sv
// writeback_stage_vec: Memory->Writeback pipeline register with the ResultW select,
// one scalar lane plus LANES vector lanes, valid tracking, stall, flush and a
// per-lane vector write mask.
// Optional feature macro: RETIRE_COUNT_EN adds a 32-bit retired-instruction counter
// on RetiredW; without it RetiredW is tied to 0 and no counter flops exist.
module writeback_stage_vec #(
    parameter int N     = 24,
    parameter int LANES = 4,
    parameter int RA    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 StallW,
    input  logic                 FlushW,
    input  logic                 ValidM,
    input  logic                 PCSrcM,
    input  logic                 RegWriteM,
    input  logic                 MemtoRegM,
    input  logic                 VecM,
    input  logic [LANES-1:0]     VMaskM,
    input  logic [RA-1:0]        WA3M,
    input  logic [N-1:0]         ReadDataM,
    input  logic [N-1:0]         ALUOutM,
    input  logic [LANES*N-1:0]   ReadDataVM,
    input  logic [LANES*N-1:0]   ALUOutVM,
    output logic                 ValidW,
    output logic                 PCSrcW,
    output logic                 RegWriteW,
    output logic [LANES-1:0]     VRegWriteW,
    output logic [RA-1:0]        WA3W,
    output logic [N-1:0]         ResultW,
    output logic [LANES*N-1:0]   ResultVW,
    output logic [31:0]          RetiredW
);

    logic                 valid_q,    valid_d;
    logic                 pcsrc_q,    pcsrc_d;
    logic                 regwrite_q, regwrite_d;
    logic                 memtoreg_q, memtoreg_d;
    logic                 vec_q,      vec_d;
    logic [LANES-1:0]     vmask_q,    vmask_d;
    logic [RA-1:0]        wa3_q,      wa3_d;
    logic [N-1:0]         rd_q,       rd_d;
    logic [N-1:0]         alu_q,      alu_d;
    logic [LANES*N-1:0]   rdv_q,      rdv_d;
    logic [LANES*N-1:0]   aluv_q,     aluv_d;

    // A load happens only when not flushing, enabled and not stalled.
    logic load;
    assign load = !FlushW && en && !StallW;

    // Next-state select: flush beats stall/disable, which beats load.
    always_comb begin
        valid_d    = valid_q;
        pcsrc_d    = pcsrc_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        vec_d      = vec_q;
        vmask_d    = vmask_q;
        wa3_d      = wa3_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        rdv_d      = rdv_q;
        aluv_d     = aluv_q;
        if (FlushW) begin
            valid_d    = 1'b0;
            pcsrc_d    = 1'b0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            vec_d      = 1'b0;
            vmask_d    = '0;
            wa3_d      = '0;
            rd_d       = '0;
            alu_d      = '0;
            rdv_d      = '0;
            aluv_d     = '0;
        end else if (load) begin
            valid_d    = ValidM;
            pcsrc_d    = PCSrcM;
            regwrite_d = RegWriteM;
            memtoreg_d = MemtoRegM;
            vec_d      = VecM;
            vmask_d    = VMaskM;
            wa3_d      = WA3M;
            rd_d       = ReadDataM;
            alu_d      = ALUOutM;
            rdv_d      = ReadDataVM;
            aluv_d     = ALUOutVM;
        end
    end

    // W register bank; reset clears control and data alike.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pcsrc_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            vec_q      <= 1'b0;
            vmask_q    <= '0;
            wa3_q      <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            rdv_q      <= '0;
            aluv_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            pcsrc_q    <= pcsrc_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            vec_q      <= vec_d;
            vmask_q    <= vmask_d;
            wa3_q      <= wa3_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            rdv_q      <= rdv_d;
            aluv_q     <= aluv_d;
        end
    end

    // Write enables are gated by ValidW so a captured bubble can never write;
    // the Vec bit steers the write to exactly one register file.
    assign ValidW     = valid_q;
    assign PCSrcW     = pcsrc_q & valid_q;
    assign RegWriteW  = regwrite_q & valid_q & ~vec_q;
    assign VRegWriteW = vmask_q & {LANES{regwrite_q & valid_q & vec_q}};
    assign WA3W       = wa3_q;
    assign ResultW    = memtoreg_q ? rd_q : alu_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign ResultVW[i*N +: N] = memtoreg_q ? rdv_q[i*N +: N] : aluv_q[i*N +: N];
    end

`ifdef RETIRE_COUNT_EN
    logic [31:0] retired_q, retired_d;

    // Count only loads that capture a real instruction; wraps naturally at 2^32.
    always_comb begin
        retired_d = retired_q;
        if (load && ValidM) retired_d = retired_q + 32'd1;
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) retired_q <= 32'd0;
        else     retired_q <= retired_d;
    end

    assign RetiredW = retired_q;
`else
    assign RetiredW = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_stage_vec.sv
// Self-checking bench for writeback_stage_vec: table of single-cycle loads with
// hand-computed expectations, directed multi-cycle sequences, and randomized
// traffic compared against a behavioural reference model.
module tb_writeback_stage_vec;
    localparam int N = 24, LANES = 4, RA = 4, VW = N * LANES;

    logic clk = 1'b0;
    logic rst, en, StallW, FlushW, ValidM, PCSrcM, RegWriteM, MemtoRegM, VecM;
    logic [LANES-1:0] VMaskM;
    logic [RA-1:0]    WA3M;
    logic [N-1:0]     ReadDataM, ALUOutM;
    logic [VW-1:0]    ReadDataVM, ALUOutVM;
    logic             ValidW, PCSrcW, RegWriteW;
    logic [LANES-1:0] VRegWriteW;
    logic [RA-1:0]    WA3W;
    logic [N-1:0]     ResultW;
    logic [VW-1:0]    ResultVW;
    logic [31:0]      RetiredW;

    writeback_stage_vec #(.N(N), .LANES(LANES), .RA(RA)) dut (
        .clk(clk), .rst(rst), .en(en), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .VecM(VecM), .VMaskM(VMaskM), .WA3M(WA3M), .ReadDataM(ReadDataM), .ALUOutM(ALUOutM),
        .ReadDataVM(ReadDataVM), .ALUOutVM(ALUOutVM), .ValidW(ValidW), .PCSrcW(PCSrcW),
        .RegWriteW(RegWriteW), .VRegWriteW(VRegWriteW), .WA3W(WA3W), .ResultW(ResultW),
        .ResultVW(ResultVW), .RetiredW(RetiredW)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction last accepted into W plus a retire count.
    typedef struct {
        logic valid, pcsrc, rw, m2r, vec;
        logic [LANES-1:0] mask;
        logic [RA-1:0] wa3;
        logic [N-1:0] rd, alu;
        logic [VW-1:0] rdv, aluv;
    } instr_t;

    instr_t      m_w;
    logic [31:0] m_ret;

    typedef struct {
        logic valid, pcsrc, rw, m2r, vec;
        logic [LANES-1:0] mask;
        logic [RA-1:0] wa3;
        logic [N-1:0] rd, alu;
        logic [VW-1:0] rdv, aluv;
        logic e_valid, e_pc, e_rw;
        logic [LANES-1:0] e_vrw;
        logic [RA-1:0] e_wa3;
        logic [N-1:0] e_res;
        logic [VW-1:0] e_resv;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_w   = '{default: '0};
        m_ret = 32'd0;
    endtask

    task automatic model_edge();
        if (FlushW) begin
            m_w = '{default: '0};
        end else if (en && !StallW) begin
            m_w.valid = ValidM;   m_w.pcsrc = PCSrcM; m_w.rw = RegWriteM;
            m_w.m2r   = MemtoRegM; m_w.vec  = VecM;   m_w.mask = VMaskM;
            m_w.wa3   = WA3M;     m_w.rd    = ReadDataM; m_w.alu = ALUOutM;
            m_w.rdv   = ReadDataVM; m_w.aluv = ALUOutVM;
            if (ValidM) m_ret = m_ret + 32'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [LANES-1:0] e_vrw;
        logic [VW-1:0]    e_resv;
        logic             writes;
        writes = m_w.valid && m_w.rw;
        e_vrw  = (writes && m_w.vec) ? m_w.mask : '0;
        for (int l = 0; l < LANES; l++)
            e_resv[l*N +: N] = m_w.m2r ? m_w.rdv[l*N +: N] : m_w.aluv[l*N +: N];
        chk({tag, ".ValidW"},     ValidW,     m_w.valid);
        chk({tag, ".PCSrcW"},     PCSrcW,     m_w.valid && m_w.pcsrc);
        chk({tag, ".RegWriteW"},  RegWriteW,  writes && !m_w.vec);
        chk({tag, ".VRegWriteW"}, VRegWriteW, e_vrw);
        chk({tag, ".WA3W"},       WA3W,       m_w.wa3);
        chk({tag, ".ResultW"},    ResultW,    m_w.m2r ? m_w.rd : m_w.alu);
        chk({tag, ".ResultVW"},   ResultVW,   e_resv);
`ifdef RETIRE_COUNT_EN
        chk({tag, ".RetiredW"},   RetiredW,   m_ret);
`else
        chk({tag, ".RetiredW"},   RetiredW,   32'd0);
`endif
    endtask

    task automatic drive(input vec_t v);
        ValidM = v.valid; PCSrcM = v.pcsrc; RegWriteM = v.rw; MemtoRegM = v.m2r;
        VecM = v.vec; VMaskM = v.mask; WA3M = v.wa3; ReadDataM = v.rd; ALUOutM = v.alu;
        ReadDataVM = v.rdv; ALUOutVM = v.aluv;
    endtask

    task automatic ctrl(input logic e, input logic s, input logic f);
        en = e; StallW = s; FlushW = f;
    endtask

    localparam logic [VW-1:0] LANES_MEM = {24'h000044, 24'h000033, 24'h000022, 24'h000011};
    localparam logic [VW-1:0] LANES_ALU = {24'hA0A0A4, 24'hA0A0A3, 24'hA0A0A2, 24'hA0A0A1};

    initial begin
        // valid pc rw m2r vec mask wa3 rd alu rdv aluv | e_valid e_pc e_rw e_vrw e_wa3 e_res e_resv
        tbl[0] = '{1,0,1,0,0,4'hF,4'd5, 24'hFFFFFF,24'h000ABC, LANES_MEM,LANES_ALU,
                   1,0,1,4'h0,4'd5, 24'h000ABC, LANES_ALU};
        tbl[1] = '{1,0,1,1,0,4'hF,4'd5, 24'h123456,24'h000ABC, LANES_MEM,LANES_ALU,
                   1,0,1,4'h0,4'd5, 24'h123456, LANES_MEM};
        tbl[2] = '{1,0,1,1,1,4'b1010,4'd9, 24'h0,24'h0, LANES_MEM,LANES_ALU,
                   1,0,0,4'b1010,4'd9, 24'h000000, LANES_MEM};
        tbl[3] = '{0,1,1,0,0,4'hF,4'd3, 24'h111111,24'h222222, LANES_MEM,LANES_ALU,
                   0,0,0,4'h0,4'd3, 24'h222222, LANES_ALU};
        tbl[4] = '{1,0,0,0,1,4'b1111,4'd7, 24'h0,24'h7FFFFF, LANES_MEM,LANES_ALU,
                   1,0,0,4'h0,4'd7, 24'h7FFFFF, LANES_ALU};
        tbl[5] = '{1,1,0,0,0,4'h0,4'd15, 24'h0,24'h800000, LANES_MEM,LANES_ALU,
                   1,1,0,4'h0,4'd15, 24'h800000, LANES_ALU};

        rst = 1'b1;
        ctrl(1'b1, 1'b0, 1'b0);
        drive('{default: '0});
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk) rst = 1'b0;

        // Table-driven single-cycle loads.
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i]);
            tick();
            chk($sformatf("tbl%0d.ValidW", i),     ValidW,     tbl[i].e_valid);
            chk($sformatf("tbl%0d.PCSrcW", i),     PCSrcW,     tbl[i].e_pc);
            chk($sformatf("tbl%0d.RegWriteW", i),  RegWriteW,  tbl[i].e_rw);
            chk($sformatf("tbl%0d.VRegWriteW", i), VRegWriteW, tbl[i].e_vrw);
            chk($sformatf("tbl%0d.WA3W", i),       WA3W,       tbl[i].e_wa3);
            chk($sformatf("tbl%0d.ResultW", i),    ResultW,    tbl[i].e_res);
            chk($sformatf("tbl%0d.ResultVW", i),   ResultVW,   tbl[i].e_resv);
        end

        // Stall holds op A while op B waits on M; release lets B in.
        for (int mode = 0; mode < 2; mode++) begin
            drive(tbl[0]); ctrl(1'b1, 1'b0, 1'b0); tick();
            drive(tbl[2]);
            if (mode == 0) ctrl(1'b1, 1'b1, 1'b0); else ctrl(1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 3; c++) begin
                tick();
                chk($sformatf("hold%0d.ResultW", mode),   ResultW,   24'h000ABC);
                chk($sformatf("hold%0d.RegWriteW", mode), RegWriteW, 1'b1);
                check_model($sformatf("hold%0d", mode));
            end
            ctrl(1'b1, 1'b0, 1'b0); tick();
            chk($sformatf("rel%0d.VRegWriteW", mode), VRegWriteW, 4'b1010);
            chk($sformatf("rel%0d.ResultVW", mode),   ResultVW,   LANES_MEM);
            chk($sformatf("rel%0d.RegWriteW", mode),  RegWriteW,  1'b0);
        end

        // Flush beats stall, and is not gated by en.
        drive(tbl[5]); ctrl(1'b1, 1'b0, 1'b0); tick();
        ctrl(1'b0, 1'b1, 1'b1); tick();
        chk("flush.ValidW",     ValidW,     1'b0);
        chk("flush.PCSrcW",     PCSrcW,     1'b0);
        chk("flush.RegWriteW",  RegWriteW,  1'b0);
        chk("flush.VRegWriteW", VRegWriteW, 4'h0);
        chk("flush.WA3W",       WA3W,       4'h0);
        chk("flush.ResultW",    ResultW,    24'h0);
        check_model("flush");

        // Asynchronous reset mid-run and mid-stall: outputs clear without an edge.
        drive(tbl[0]); ctrl(1'b1, 1'b0, 1'b0); tick();
        ctrl(1'b1, 1'b1, 1'b0);
        rst = 1'b1; #1;
        model_reset();
        chk("rstmid.ValidW",  ValidW,  1'b0);
        chk("rstmid.ResultW", ResultW, 24'h0);
        check_model("rstmid");
        @(negedge clk) rst = 1'b0;
        ctrl(1'b1, 1'b0, 1'b0); tick();
        check_model("rstrel");

        // Retire count: 5 valid loads, 1 bubble, 2 stalls, 1 flush.
        rst = 1'b1; #1; model_reset();
        @(negedge clk) rst = 1'b0;
        drive(tbl[0]);
        for (int c = 0; c < 5; c++) tick();
        ValidM = 1'b0; tick();
        ValidM = 1'b1; ctrl(1'b1, 1'b1, 1'b0); tick(); tick();
        ctrl(1'b1, 1'b0, 1'b1); tick();
        ctrl(1'b1, 1'b0, 1'b0);
`ifdef RETIRE_COUNT_EN
        chk("retire.count", RetiredW, 32'd5);
        force dut.retired_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        m_ret = 32'hFFFFFFFF;
        tick();
        chk("retire.wrap", RetiredW, 32'd0);
`else
        chk("retire.count", RetiredW, 32'd0);
`endif
        check_model("retire");

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            ValidM = 1'($urandom); PCSrcM = 1'($urandom); RegWriteM = 1'($urandom);
            MemtoRegM = 1'($urandom); VecM = 1'($urandom); VMaskM = 4'($urandom);
            WA3M = 4'($urandom); ReadDataM = 24'($urandom); ALUOutM = 24'($urandom);
            ReadDataVM = {$urandom, $urandom, $urandom};
            ALUOutVM   = {$urandom, $urandom, $urandom};
            ctrl(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0));
            tick();
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
